// File: rtl/ucaspian_axon.sv
// ucaspian_axon: buffers neuron fires and expands each into its configured
// contiguous run of synapse addresses, one per downstream handshake.
module ucaspian_axon #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        clear_act,
    input  logic        clear_config,
    output logic        clear_done,
    input  logic [7:0]  config_addr,
    input  logic [11:0] config_value,
    input  logic [2:0]  config_byte,
    input  logic        config_enable,
    output logic        step_done,
    input  logic [7:0]  axon_addr,
    input  logic        axon_vld,
    output logic        axon_rdy,
    output logic [11:0] synapse_addr,
    output logic        synapse_vld,
    input  logic        synapse_rdy
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, READ, EMIT} state_t;

    state_t      state;
    logic [19:0] cfg_mem [256];
    logic [19:0] cfg_q;
    logic [11:0] start_hold;
    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [7:0]  count, idx, sweep;
    logic        clearing, empty, full, push, pop, cfg_wr;

    assign clearing = clear_act | clear_config;
    assign empty    = wr_ptr == rd_ptr;
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign axon_rdy = ~full & ~clearing & ~reset;
    assign push     = axon_vld & axon_rdy;
    assign pop      = (state == IDLE) & enable & ~empty & ~clearing;
    assign cfg_wr   = config_enable & (config_byte == 3'd2);

    // Storage arrays carry no reset; config contents survive reset and clear_act.
    always_ff @(posedge clk) begin
        if (cfg_wr)
            cfg_mem[config_addr] <= {config_value[7:0], start_hold};
        else if (clear_config && !clear_done && !reset)
            cfg_mem[sweep] <= '0;
        if (push)
            fifo_mem[wr_ptr[AW-1:0]] <= axon_addr;
        cfg_q <= cfg_mem[fifo_mem[rd_ptr[AW-1:0]]];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            synapse_vld  <= 1'b0;
            synapse_addr <= '0;
            count        <= '0;
            idx          <= '0;
            start_hold   <= '0;
            sweep        <= '0;
            clear_done   <= 1'b0;
            step_done    <= 1'b0;
        end else begin
            if (config_enable && config_byte == 3'd1)
                start_hold <= config_value;
            step_done <= empty & (state == IDLE) & ~synapse_vld & ~axon_vld & ~clearing;
            if (clearing) begin
                state       <= IDLE;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                synapse_vld <= 1'b0;
                if (!clear_done) begin
                    sweep      <= sweep + 8'd1;
                    clear_done <= sweep == 8'hFF;
                end
            end else begin
                sweep      <= '0;
                clear_done <= 1'b0;
                if (push)
                    wr_ptr <= wr_ptr + (AW+1)'(1);
                if (pop)
                    rd_ptr <= rd_ptr + (AW+1)'(1);
                case (state)
                    IDLE: if (pop) state <= READ;
                    READ: begin
                        count <= cfg_q[19:12];
                        idx   <= '0;
                        if (cfg_q[19:12] != 8'd0) begin
                            state        <= EMIT;
                            synapse_vld  <= 1'b1;
                            synapse_addr <= cfg_q[11:0];
                        end else begin
                            state <= IDLE;
                        end
                    end
                    EMIT: if (synapse_rdy) begin
                        if (idx == count - 8'd1) begin
                            synapse_vld <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            idx          <= idx + 8'd1;
                            synapse_addr <= synapse_addr + 12'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ucaspian_axon.sv
// tb_ucaspian_axon: vector table, hand sequences and randomized fires checked
// against a per-neuron expansion model.
module tb_ucaspian_axon;
    logic        clk = 0, reset = 1, enable = 0, clear_act = 0, clear_config = 0;
    logic        config_enable = 0, axon_vld = 0, synapse_rdy = 0;
    logic [7:0]  config_addr = 0, axon_addr = 0;
    logic [11:0] config_value = 0;
    logic [2:0]  config_byte = 0;
    logic        clear_done, step_done, axon_rdy, synapse_vld;
    logic [11:0] synapse_addr;

    int          n_checks = 0, n_fail = 0, cyc = 0;
    bit          rnd_rdy = 0;
    logic [11:0] got[$], exp_q[$];
    int          got_cyc[$], push_cyc[$];
    logic [11:0] m_start [256];
    logic [7:0]  m_count [256];
    logic        stall_q = 0;
    logic [11:0] stall_addr = 0;
    logic [7:0]  nl [6];

    typedef struct {
        logic [7:0]  n;
        logic [11:0] s;
        logic [7:0]  c;
        int          exp_n;
        logic [11:0] exp_first;
        logic [11:0] exp_last;
    } vec_t;
    vec_t vecs [6];

    ucaspian_axon dut (
        .clk(clk), .reset(reset), .enable(enable),
        .clear_act(clear_act), .clear_config(clear_config), .clear_done(clear_done),
        .config_addr(config_addr), .config_value(config_value),
        .config_byte(config_byte), .config_enable(config_enable),
        .step_done(step_done),
        .axon_addr(axon_addr), .axon_vld(axon_vld), .axon_rdy(axon_rdy),
        .synapse_addr(synapse_addr), .synapse_vld(synapse_vld), .synapse_rdy(synapse_rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // A stalled output must hold its address and valid into the next edge.
    always @(posedge clk) begin
        if (stall_q) begin
            check("hold_vld", 32'(synapse_vld), 1);
            check("hold_addr", 32'(synapse_addr), 32'(stall_addr));
        end
        stall_q    <= synapse_vld & ~synapse_rdy & ~reset & ~clear_act & ~clear_config;
        stall_addr <= synapse_addr;
        if (axon_vld && axon_rdy)
            push_cyc.push_back(cyc);
        if (synapse_vld && synapse_rdy) begin
            got.push_back(synapse_addr);
            got_cyc.push_back(cyc);
        end
        cyc <= cyc + 1;
    end

    task automatic tick();
        @(negedge clk);
        if (rnd_rdy)
            synapse_rdy = $urandom_range(0, 3) != 0;
    endtask

    task automatic clr_q();
        got.delete(); got_cyc.delete(); push_cyc.delete(); exp_q.delete();
    endtask

    task automatic add_exp(input logic [7:0] n);
        for (int i = 0; i < int'(m_count[n]); i++)
            exp_q.push_back(12'((int'(m_start[n]) + i) % 4096));
    endtask

    task automatic cfg(input logic [7:0] n, input logic [11:0] s, input logic [7:0] c);
        config_addr = n; config_enable = 1; config_byte = 1; config_value = s;
        tick();
        config_byte = 2; config_value = {4'h0, c};
        tick();
        config_enable = 0; config_byte = 0;
        m_start[n] = s; m_count[n] = c;
    endtask

    task automatic fire(input logic [7:0] n);
        int k = 0;
        axon_addr = n; axon_vld = 1;
        while (!axon_rdy && k < 200) begin
            if (k == 50) enable = 1;
            tick(); k++;
        end
        check("fire_accept", 32'(axon_rdy), 1);
        tick();
        axon_vld = 0;
        add_exp(n);
    endtask

    task automatic drain(input string name);
        int k = 0;
        enable = 1; rnd_rdy = 0; synapse_rdy = 1;
        do begin tick(); k++; end while (!step_done && k < 3000);
        check(name, 32'(step_done), 1);
    endtask

    task automatic wait_vld(input string name);
        int k = 0;
        while (!synapse_vld && k < 50) begin tick(); k++; end
        check(name, 32'(synapse_vld), 1);
    endtask

    task automatic cmp_q(input string name);
        check({name, "_len"}, 32'(got.size()), 32'(exp_q.size()));
        foreach (exp_q[i])
            check(name, i < got.size() ? 32'(got[i]) : 32'hDEADBEEF, 32'(exp_q[i]));
        clr_q();
    endtask

    initial begin
        vecs = '{
            '{8'd5,   12'h100, 8'd3,   3,   12'h100, 12'h102},
            '{8'd7,   12'hFFE, 8'd4,   4,   12'hFFE, 12'h001},
            '{8'd9,   12'h200, 8'd0,   0,   12'h000, 12'h000},
            '{8'd11,  12'hFFF, 8'd1,   1,   12'hFFF, 12'hFFF},
            '{8'd13,  12'hF80, 8'd200, 200, 12'hF80, 12'h047},
            '{8'd200, 12'h000, 8'd255, 255, 12'h000, 12'h0FE}
        };
        foreach (m_count[i]) begin m_count[i] = 0; m_start[i] = 0; end

        repeat (3) tick();
        check("rst_axon_rdy", 32'(axon_rdy), 0);
        check("rst_vld", 32'(synapse_vld), 0);
        check("rst_addr", 32'(synapse_addr), 0);
        check("rst_clear_done", 32'(clear_done), 0);
        check("rst_step_done", 32'(step_done), 0);
        reset = 0;
        tick();
        check("rdy_after_reset", 32'(axon_rdy), 1);

        enable = 1; synapse_rdy = 1;
        foreach (vecs[r]) cfg(vecs[r].n, vecs[r].s, vecs[r].c);
        foreach (vecs[r]) begin
            clr_q();
            fire(vecs[r].n);
            drain("tbl_drain");
            check("tbl_len", 32'(got.size()), 32'(vecs[r].exp_n));
            if (vecs[r].exp_n > 0 && got.size() == vecs[r].exp_n) begin
                check("tbl_first", 32'(got[0]), 32'(vecs[r].exp_first));
                check("tbl_last", 32'(got[got.size()-1]), 32'(vecs[r].exp_last));
                check("tbl_latency", 32'(got_cyc[0] - push_cyc[0]), 3);
                check("tbl_span", 32'(got_cyc[got.size()-1] - got_cyc[0]), 32'(vecs[r].exp_n - 1));
            end
            cmp_q("tbl_seq");
        end

        // downstream stall in the middle of a run
        clr_q();
        synapse_rdy = 0;
        fire(8'd5);
        wait_vld("stall_vld");
        check("stall_first", 32'(synapse_addr), 32'h100);
        synapse_rdy = 1;
        tick();
        synapse_rdy = 0;
        for (int i = 0; i < 5; i++) begin
            check("stall_hold_vld", 32'(synapse_vld), 1);
            check("stall_hold_addr", 32'(synapse_addr), 32'h101);
            tick();
        end
        drain("stall_drain");
        cmp_q("stall_seq");

        // FIFO fills at 16 with popping disabled
        clr_q();
        enable = 0; synapse_rdy = 0;
        axon_addr = 8'd9; axon_vld = 1;
        repeat (20) tick();
        check("full_accepted", 32'(push_cyc.size()), 16);
        check("full_rdy_low", 32'(axon_rdy), 0);
        axon_vld = 0;
        drain("full_drain");
        check("full_no_out", 32'(got.size()), 0);
        check("full_total", 32'(push_cyc.size()), 16);

        // enable gates pops; runs emerge in order with a 2-cycle bubble
        clr_q();
        enable = 0; synapse_rdy = 1;
        fire(8'd5);
        fire(8'd7);
        repeat (10) tick();
        check("en0_no_out", 32'(got.size()), 0);
        check("en0_vld", 32'(synapse_vld), 0);
        drain("en_drain");
        check("en_gap", got.size() == 7 ? 32'(got_cyc[3] - got_cyc[2]) : 32'hFFFF_FFFF, 3);
        cmp_q("en_seq");

        // clear_config mid-run wipes config
        synapse_rdy = 0;
        fire(8'd5);
        wait_vld("cc_vld");
        clear_config = 1;
        tick();
        check("cc_vld_drop", 32'(synapse_vld), 0);
        check("cc_axon_rdy", 32'(axon_rdy), 0);
        begin
            int k = 1;
            while (!clear_done && k < 400) begin tick(); k++; end
            check("cc_cycles", 32'(k), 256);
        end
        tick();
        check("cc_done_hold", 32'(clear_done), 1);
        clear_config = 0;
        foreach (m_count[i]) begin m_count[i] = 0; m_start[i] = 0; end
        tick();
        check("cc_done_low", 32'(clear_done), 0);
        clr_q();
        synapse_rdy = 1;
        fire(8'd5);
        drain("cc_drain");
        cmp_q("cc_post");

        // clear_act mid-run keeps config
        cfg(8'd5, 12'h100, 8'd3);
        cfg(8'd7, 12'hFFE, 8'd4);
        synapse_rdy = 0;
        fire(8'd5);
        wait_vld("ca_vld");
        clear_act = 1;
        tick();
        check("ca_vld_drop", 32'(synapse_vld), 0);
        begin
            int k = 1;
            while (!clear_done && k < 400) begin tick(); k++; end
            check("ca_cycles", 32'(k), 256);
        end
        clear_act = 0;
        tick();
        clr_q();
        fire(8'd5);
        drain("ca_drain");
        cmp_q("ca_post");

        // reset mid-run keeps config
        synapse_rdy = 0;
        fire(8'd7);
        wait_vld("rr_vld");
        reset = 1;
        tick();
        check("rr_vld", 32'(synapse_vld), 0);
        check("rr_addr", 32'(synapse_addr), 0);
        check("rr_axon_rdy", 32'(axon_rdy), 0);
        check("rr_step_done", 32'(step_done), 0);
        reset = 0;
        tick();
        check("rr_rdy_back", 32'(axon_rdy), 1);
        clr_q();
        fire(8'd7);
        drain("rr_drain");
        cmp_q("rr_post");

        // randomized fires with random back-pressure and enable
        for (int i = 0; i < 6; i++) begin
            nl[i] = 8'($urandom_range(100, 199));
            cfg(nl[i], 12'($urandom), 8'($urandom_range(0, 6)));
        end
        clr_q();
        rnd_rdy = 1;
        for (int i = 0; i < 40; i++) begin
            enable = $urandom_range(0, 4) != 0;
            fire(nl[$urandom_range(0, 5)]);
            repeat ($urandom_range(0, 3)) tick();
        end
        drain("rand_drain");
        cmp_q("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
